seq_datapath: RTL and testbench
===============================

Name: seq_datapath

Overview:
- Parametrised successor to the single-width datapath.
- Contains a NREGS x WIDTH register file, A/B/C pipeline registers, a shifter, a 4-op ALU and Z/N/V status flags.
- An internal sequencer runs the read-A / read-B / execute / writeback cycles from one start command, so the controller no longer toggles loada/loadb/loadc itself.
- A separate external write port loads registers from mdata, sximm8, PC or C.

Parameters:
- WIDTH, 16: datapath and register width.
- NREGS, 8: register count, power of 2, >= 2. RW = $clog2(NREGS).
- PCW, 9: PC input width, <= WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command valid; accepted only when ready=1.
- ready  out  1  high in IDLE.
- ra, rb, rd  in  RW each  source A, source B, destination register.
- shift  in  2  00 none, 01 LSL1, 10 LSR1, 11 ASR1.
- alu_op  in  2  00 ADD, 01 SUB, 10 AND, 11 NOT B.
- asel  in  1  1 forces ALU A input to 0.
- bsel  in  1  1 selects imm instead of the shifted B.
- imm  in  WIDTH  sign-extended immediate (sximm5 equivalent).
- wb_en  in  1  write C back to rd.
- set_flags  in  1  update Z/N/V in EXEC.
- ext_we  in  1  external register write.
- ext_wnum  in  RW  external write target.
- ext_vsel  in  2  00 mdata, 01 sximm8, 10 pc zero-extended, 11 C.
- mdata, sximm8  in  WIDTH each.
- pc  in  PCW.
- done  out  1  one-cycle pulse when the command completes.
- datapath_out  out  WIDTH  C register.
- Z_out, N_out, V_out  out  1 each  status register.

Behaviour:
- Reset (async, rst_n=0):
  - All registers, A, B and C clear to 0.
  - Z/N/V=0, done=0, state=IDLE, ready=1.
  - Reset asserted mid-command aborts it: no writeback, no flag update, no done pulse.
- Command capture: in IDLE, start=1 latches ra, rb, rd, shift, alu_op, asel, bsel, imm, wb_en and set_flags into a command register. The inputs may change afterwards.
- start with ready=0 is ignored and not queued.
- State machine:
  - IDLE -> RDA on accepted start.
  - RDA: A <= R[ra]. -> RDB.
  - RDB: B <= R[rb]. -> EXEC.
  - EXEC: C <= ALU result. If set_flags, Z/N/V <= flags. -> WB if wb_en, else -> IDLE with done=1 on that transition.
  - WB: R[rd] <= C. -> IDLE, done=1.
- Latency: start accepted at edge 0 gives done high after edge 3 (no wb) or edge 4 (wb). ready returns the same cycle done is high.
- Shifter:
  - LSL1 shifts in 0 at the LSB.
  - LSR1 shifts in 0 at the MSB.
  - ASR1 replicates the MSB.
- Operands: Ain = asel ? 0 : A. Bin = bsel ? imm : shift(B).
- ALU results are WIDTH bits and wrap mod 2^WIDTH.
- Flags:
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - V = two's-complement overflow for ADD/SUB. V = 0 for AND and NOT.
- External write port:
  - Writes on any clk edge with ext_we=1, independent of state.
  - If WB and ext_we target the same register on the same edge, WB wins.
  - ext_vsel=11 writes the current C.
- datapath_out always shows C. It is unchanged except in EXEC.

Optional Feature:
- Macro: SEQ_DATAPATH_BYPASS_EN.
- Defined: in RDA/RDB, if ext_we=1 and ext_wnum equals the register being read, A/B capture the external write data (write-through bypass).
- Undefined: A/B capture the pre-write register value; the external write lands on the same edge but is not seen.

Test Plan:
- Reset and flags: reset during EXEC of ADD R1,R2 with wb_en=1 -> rd unchanged, done never pulses, ready=1, Z/N/V=0.
- ADD and latency: ext-write R1=8, R2=2 via sximm8; start ADD ra=1, rb=2, shift=01, wb_en=1, rd=3 -> datapath_out=0x000C. done is high exactly 4 edges after start. Read back R3=0x000C with ADD R3 + imm 0, asel=0, bsel=1.
- SUB with flags: R6=14, R7=34, SUB set_flags=1 -> datapath_out=0xFFEC, N=1, Z=0, V=0.
- ADD overflow: R6=0x7FFF, R7=0x0001, ADD set_flags=1 -> 0x8000, V=1, N=1, Z=0.
- ASR and immediate: R1=0x8004, ADD asel=1, shift=11 -> 0xC002. Then asel=1, bsel=1, imm=7, ADD -> 0x0007, and Z/N/V unchanged when set_flags=0.
- Conflicts: start while busy -> ignored. WB and ext_we to the same rd on the same edge -> R[rd]=C. ext write to ra during RDA -> A gets the new value with the macro defined, the old value without it.

Source files
------------

// File: rtl/seq_datapath.sv
// seq_datapath: sequenced register-file datapath with shifter, 4-op ALU and Z/N/V flags
//
// Optional feature: define SEQ_DATAPATH_BYPASS_EN to let A/B capture an external
// write that targets the register being read on the same edge (write-through).
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start / ready         command handshake; a command is accepted only in IDLE
//   ra, rb, rd            source A, source B and destination register numbers
//   shift                 00 none, 01 LSL1, 10 LSR1, 11 ASR1 (applied to B)
//   alu_op                00 ADD, 01 SUB, 10 AND, 11 NOT B
//   asel, bsel, imm       zero the A operand / use imm instead of shifted B
//   wb_en, set_flags      write C back to rd / update Z/N/V in EXEC
//   ext_we, ext_wnum,     external register write port; ext_vsel picks
//   ext_vsel, mdata,      mdata, sximm8, zero-extended pc or C
//   sximm8, pc
//   done                  one-cycle pulse when a command completes
//   datapath_out          C register
//   Z_out, N_out, V_out   status register
module seq_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PCW = 9,
    localparam int RW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [RW-1:0]    ra,
    input  logic [RW-1:0]    rb,
    input  logic [RW-1:0]    rd,
    input  logic [1:0]       shift,
    input  logic [1:0]       alu_op,
    input  logic             asel,
    input  logic             bsel,
    input  logic [WIDTH-1:0] imm,
    input  logic             wb_en,
    input  logic             set_flags,
    input  logic             ext_we,
    input  logic [RW-1:0]    ext_wnum,
    input  logic [1:0]       ext_vsel,
    input  logic [WIDTH-1:0] mdata,
    input  logic [WIDTH-1:0] sximm8,
    input  logic [PCW-1:0]   pc,
    output logic             done,
    output logic [WIDTH-1:0] datapath_out,
    output logic             Z_out,
    output logic             N_out,
    output logic             V_out
);

    typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;

    state_t state, state_nxt;
    logic done_nxt;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] a, b, c;
    logic z, n, v;

    logic [RW-1:0]    c_ra, c_rb, c_rd;
    logic [1:0]       c_shift, c_op;
    logic             c_asel, c_bsel, c_wb, c_sf;
    logic [WIDTH-1:0] c_imm;

    logic [WIDTH-1:0] pc_ext, ext_data, a_src, b_src;
    logic [WIDTH-1:0] ain, bsh, bin, sum, diff, res;
    logic             res_v;
    logic             accept;

    assign accept = (state == IDLE) && start;

    // State register; done is registered so it pulses in the cycle IDLE is re-entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RDA : IDLE;
            RDA:     state_nxt = RDB;
            RDB:     state_nxt = EXEC;
            EXEC:    state_nxt = c_wb ? WB : IDLE;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready    = (state == IDLE);
        done_nxt = ((state == EXEC) && !c_wb) || (state == WB);
    end

    // Command register: inputs are sampled once so the controller may move on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_ra    <= '0;
            c_rb    <= '0;
            c_rd    <= '0;
            c_shift <= '0;
            c_op    <= '0;
            c_asel  <= 1'b0;
            c_bsel  <= 1'b0;
            c_imm   <= '0;
            c_wb    <= 1'b0;
            c_sf    <= 1'b0;
        end else if (accept) begin
            c_ra    <= ra;
            c_rb    <= rb;
            c_rd    <= rd;
            c_shift <= shift;
            c_op    <= alu_op;
            c_asel  <= asel;
            c_bsel  <= bsel;
            c_imm   <= imm;
            c_wb    <= wb_en;
            c_sf    <= set_flags;
        end
    end

    always_comb begin
        pc_ext = '0;
        pc_ext[PCW-1:0] = pc;
        ext_data = ext_vsel == 2'b00 ? mdata :
                   ext_vsel == 2'b01 ? sximm8 :
                   ext_vsel == 2'b10 ? pc_ext : c;
    end

    // Register file; the writeback assignment comes last so it wins a same-edge conflict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            if (ext_we)
                regs[ext_wnum] <= ext_data;
            if (state == WB)
                regs[c_rd] <= c;
        end
    end

`ifdef SEQ_DATAPATH_BYPASS_EN
    assign a_src = (ext_we && ext_wnum == c_ra) ? ext_data : regs[c_ra];
    assign b_src = (ext_we && ext_wnum == c_rb) ? ext_data : regs[c_rb];
`else
    assign a_src = regs[c_ra];
    assign b_src = regs[c_rb];
`endif

    always_comb begin
        ain  = c_asel ? '0 : a;
        bsh  = c_shift == 2'b01 ? {b[WIDTH-2:0], 1'b0} :
               c_shift == 2'b10 ? {1'b0, b[WIDTH-1:1]} :
               c_shift == 2'b11 ? {b[WIDTH-1], b[WIDTH-1:1]} : b;
        bin  = c_bsel ? c_imm : bsh;
        sum  = ain + bin;
        diff = ain - bin;
        res  = c_op == 2'b00 ? sum :
               c_op == 2'b01 ? diff :
               c_op == 2'b10 ? (ain & bin) : ~bin;
        // Overflow: operands agree (ADD) or differ (SUB) in sign and the result sign flips
        res_v = c_op == 2'b00 ? (ain[WIDTH-1] == bin[WIDTH-1]) && (sum[WIDTH-1] != ain[WIDTH-1]) :
                c_op == 2'b01 ? (ain[WIDTH-1] != bin[WIDTH-1]) && (diff[WIDTH-1] != ain[WIDTH-1]) :
                1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
            c <= '0;
            z <= 1'b0;
            n <= 1'b0;
            v <= 1'b0;
        end else begin
            if (state == RDA)
                a <= a_src;
            if (state == RDB)
                b <= b_src;
            if (state == EXEC) begin
                c <= res;
                if (c_sf) begin
                    z <= (res == '0);
                    n <= res[WIDTH-1];
                    v <= res_v;
                end
            end
        end
    end

    assign datapath_out = c;
    assign Z_out = z;
    assign N_out = n;
    assign V_out = v;

endmodule

// File: tb/tb_seq_datapath.sv
// tb_seq_datapath: directed scoreboard bench for seq_datapath
module tb_seq_datapath;

    typedef struct packed {
        logic [15:0] c;
        logic z;
        logic n;
        logic v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic [2:0]  ra, rb, rd;
    logic [1:0]  shift, alu_op;
    logic        asel, bsel;
    logic [15:0] imm;
    logic        wb_en, set_flags;
    logic        ext_we;
    logic [2:0]  ext_wnum;
    logic [1:0]  ext_vsel;
    logic [15:0] mdata, sximm8;
    logic [8:0]  pc;
    logic        done;
    logic [15:0] datapath_out;
    logic        Z_out, N_out, V_out;

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    seq_datapath dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
        .ra(ra), .rb(rb), .rd(rd), .shift(shift), .alu_op(alu_op),
        .asel(asel), .bsel(bsel), .imm(imm), .wb_en(wb_en), .set_flags(set_flags),
        .ext_we(ext_we), .ext_wnum(ext_wnum), .ext_vsel(ext_vsel),
        .mdata(mdata), .sximm8(sximm8), .pc(pc), .done(done),
        .datapath_out(datapath_out), .Z_out(Z_out), .N_out(N_out), .V_out(V_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic ext_wr(input logic [2:0] num, input logic [1:0] vsel, input logic [15:0] val);
        ext_we = 1'b1;
        ext_wnum = num;
        ext_vsel = vsel;
        mdata = val;
        sximm8 = val;
        pc = val[8:0];
        tick();
        ext_we = 1'b0;
    endtask

    task automatic run(input logic [2:0] a_, input logic [2:0] b_, input logic [2:0] d_,
                       input logic [1:0] sh, input logic [1:0] op, input logic as, input logic bs,
                       input logic [15:0] im, input logic wb, input logic sf,
                       input int ext_at, input logic [2:0] en, input logic [15:0] ev,
                       input bit busy, input int lat, input exp_t e, input string tag);
        int cnt;
        bit seen;
        exp_t got;
        q.push_back(e);
        ra = a_; rb = b_; rd = d_; shift = sh; alu_op = op;
        asel = as; bsel = bs; imm = im; wb_en = wb; set_flags = sf;
        start = 1'b1;
        tick();
        start = 1'b0;
        // scramble the command inputs: the DUT must hold its captured copy
        ra = ~a_; rb = ~b_; rd = ~d_; shift = ~sh; alu_op = ~op;
        asel = ~as; bsel = ~bs; imm = ~im; wb_en = ~wb; set_flags = ~sf;
        check1({tag, "_busy"}, ready, 1'b0);
        cnt = 0;
        seen = 0;
        while (!seen && cnt < 10) begin
            ext_we = (cnt == ext_at);
            ext_wnum = en;
            ext_vsel = 2'b01;
            sximm8 = ev;
            start = busy && (cnt == 1);
            tick();
            cnt++;
            seen = done;
        end
        ext_we = 1'b0;
        start = 1'b0;
        check1({tag, "_done"}, seen, 1'b1);
        check({tag, "_lat"}, 16'(cnt), 16'(lat));
        got = q.pop_front();
        check({tag, "_c"}, datapath_out, got.c);
        check1({tag, "_z"}, Z_out, got.z);
        check1({tag, "_n"}, N_out, got.n);
        check1({tag, "_v"}, V_out, got.v);
        check1({tag, "_ready"}, ready, 1'b1);
        tick();
        check1({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        logic [15:0] byp_exp;
        int dn;
        rst_n = 1'b0;
        start = 0; ra = 0; rb = 0; rd = 0; shift = 0; alu_op = 0;
        asel = 0; bsel = 0; imm = 0; wb_en = 0; set_flags = 0;
        ext_we = 0; ext_wnum = 0; ext_vsel = 0; mdata = 0; sximm8 = 0; pc = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check1("rst_ready", ready, 1'b1);
        check1("rst_done", done, 1'b0);
        check("rst_out", datapath_out, 16'h0000);
        check1("rst_z", Z_out, 1'b0);
        check1("rst_n", N_out, 1'b0);
        check1("rst_v", V_out, 1'b0);

        ext_wr(1, 2'b01, 16'd8);
        ext_wr(2, 2'b01, 16'd2);
        run(1, 2, 3, 2'b01, 2'b00, 0, 0, 16'h0, 1, 0, -1, 0, 0, 0, 4, '{16'h000C, 0, 0, 0}, "add_lsl");
        run(3, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0, 0, 0, -1, 0, 0, 0, 3, '{16'h000C, 0, 0, 0}, "rd_r3");

        ext_wr(6, 2'b01, 16'd14);
        ext_wr(7, 2'b01, 16'd34);
        run(6, 7, 0, 2'b00, 2'b01, 0, 0, 16'h0, 0, 1, -1, 0, 0, 0, 3, '{16'hFFEC, 0, 1, 0}, "sub_neg");
        run(6, 6, 0, 2'b00, 2'b01, 0, 0, 16'h0, 0, 1, -1, 0, 0, 0, 3, '{16'h0000, 1, 0, 0}, "sub_zero");

        ext_wr(6, 2'b01, 16'h7FFF);
        ext_wr(7, 2'b01, 16'h0001);
        run(6, 7, 0, 2'b00, 2'b00, 0, 0, 16'h0, 0, 1, -1, 0, 0, 0, 3, '{16'h8000, 0, 1, 1}, "add_ovf");
        run(6, 7, 0, 2'b00, 2'b10, 0, 0, 16'h0, 0, 1, -1, 0, 0, 0, 3, '{16'h0001, 0, 0, 0}, "and");
        run(0, 7, 0, 2'b00, 2'b11, 0, 0, 16'h0, 0, 1, -1, 0, 0, 0, 3, '{16'hFFFE, 0, 1, 0}, "not_b");
        ext_wr(6, 2'b01, 16'h8000);
        run(6, 7, 0, 2'b00, 2'b01, 0, 0, 16'h0, 0, 1, -1, 0, 0, 0, 3, '{16'h7FFF, 0, 0, 1}, "sub_ovf");

        ext_wr(1, 2'b01, 16'h8004);
        run(0, 1, 0, 2'b11, 2'b00, 1, 0, 16'h0, 0, 0, -1, 0, 0, 0, 3, '{16'hC002, 0, 0, 1}, "asr");
        run(0, 1, 0, 2'b10, 2'b00, 1, 0, 16'h0, 0, 0, -1, 0, 0, 0, 3, '{16'h4002, 0, 0, 1}, "lsr");
        run(0, 0, 0, 2'b00, 2'b00, 1, 1, 16'h7, 0, 0, -1, 0, 0, 0, 3, '{16'h0007, 0, 0, 1}, "imm");

        // start while busy must be dropped, not queued
        run(6, 7, 4, 2'b00, 2'b00, 0, 0, 16'h0, 1, 0, -1, 0, 0, 1, 4, '{16'h8001, 0, 0, 1}, "busy");
        dn = 0;
        repeat (5) begin
            tick();
            dn += int'(done);
        end
        check("busy_nodone", 16'(dn), 16'd0);
        check1("busy_idle", ready, 1'b1);
        run(4, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0, 0, 0, -1, 0, 0, 0, 3, '{16'h8001, 0, 0, 1}, "rd_r4");

        // WB and an external write to the same register on the same edge
        run(0, 0, 5, 2'b00, 2'b00, 1, 1, 16'h1234, 1, 0, 3, 5, 16'hBEEF, 0, 4, '{16'h1234, 0, 0, 1}, "wb_conf");
        run(5, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0, 0, 0, -1, 0, 0, 0, 3, '{16'h1234, 0, 0, 1}, "rd_r5");

        ext_wr(6, 2'b11, 16'h0);
        run(6, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0, 0, 0, -1, 0, 0, 0, 3, '{16'h1234, 0, 0, 1}, "ext_c");
        ext_wr(7, 2'b10, 16'hFFA5);
        run(7, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0, 0, 0, -1, 0, 0, 0, 3, '{16'h01A5, 0, 0, 1}, "ext_pc");
        ext_wr(2, 2'b00, 16'h5A5A);
        run(2, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0, 0, 0, -1, 0, 0, 0, 3, '{16'h5A5A, 0, 0, 1}, "ext_md");

        // external write to ra while A is being read
        ext_wr(1, 2'b01, 16'h0011);
`ifdef SEQ_DATAPATH_BYPASS_EN
        byp_exp = 16'h0022;
`else
        byp_exp = 16'h0011;
`endif
        run(1, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0, 0, 0, 0, 1, 16'h0022, 0, 3, '{byp_exp, 0, 0, 1}, "bypass");
        run(1, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0, 0, 0, -1, 0, 0, 0, 3, '{16'h0022, 0, 0, 1}, "rd_r1");

        // reset during EXEC aborts the command
        ext_wr(1, 2'b01, 16'd5);
        ext_wr(2, 2'b01, 16'd3);
        ra = 1; rb = 2; rd = 4; shift = 0; alu_op = 0; asel = 0; bsel = 0;
        wb_en = 1; set_flags = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check1("abort_ready", ready, 1'b1);
        check1("abort_done", done, 1'b0);
        check("abort_out", datapath_out, 16'h0000);
        check1("abort_z", Z_out, 1'b0);
        check1("abort_n", N_out, 1'b0);
        check1("abort_v", V_out, 1'b0);
        tick();
        rst_n = 1'b1;
        dn = 0;
        repeat (5) begin
            tick();
            dn += int'(done);
        end
        check("abort_nodone", 16'(dn), 16'd0);
        run(4, 0, 0, 2'b00, 2'b00, 0, 1, 16'h0, 0, 0, -1, 0, 0, 0, 3, '{16'h0000, 0, 0, 0}, "abort_r4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
